// File: rtl/instr_decode_issue.sv
// Decode-and-issue stage for the 16-bit core: one instruction per cycle in, registered ALU/RF bundle out.
// Optional build macro DECODE_ILLEGAL_TRAP_EN: illegal opcodes are flagged and halt the stage.
module instr_decode_issue #(
    parameter int INSTR_WIDTH = 16,
    parameter int REG_IDX_W   = 3,
    parameter int LINK_REG    = 7
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    input  logic [INSTR_WIDTH-1:0] in_instr,
    output logic                   in_ready,
    input  logic                   flush,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [4:0]             out_alu_op,
    output logic [1:0]             out_alu_funct,
    output logic [REG_IDX_W-1:0]   out_rs,
    output logic [REG_IDX_W-1:0]   out_rt,
    output logic [REG_IDX_W-1:0]   out_rd,
    output logic [INSTR_WIDTH-1:0] out_imm,
    output logic                   out_b_imm,
    output logic                   out_wr_en,
    output logic                   out_illegal,
    output logic                   halted
);

    typedef enum logic [0:0] {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } state_t;

    localparam logic [REG_IDX_W-1:0] LINK_IDX = REG_IDX_W'(LINK_REG);

    state_t                 state_r;
    state_t                 state_nxt_s;
    logic [4:0]             opcode_s;
    logic                   accept_s;
    logic                   flush_run_s;
    logic [1:0]             dec_funct_s;
    logic [REG_IDX_W-1:0]   dec_rs_s;
    logic [REG_IDX_W-1:0]   dec_rt_s;
    logic [REG_IDX_W-1:0]   dec_rd_s;
    logic [INSTR_WIDTH-1:0] dec_imm_s;
    logic                   dec_b_imm_s;
    logic                   dec_wr_en_s;
    logic                   dec_illegal_s;
    logic                   dec_stop_s;

    function automatic logic [INSTR_WIDTH-1:0] sext5(input logic [4:0] v);
        return {{(INSTR_WIDTH-5){v[4]}}, v};
    endfunction

    function automatic logic [INSTR_WIDTH-1:0] zext5(input logic [4:0] v);
        return {{(INSTR_WIDTH-5){1'b0}}, v};
    endfunction

    function automatic logic [INSTR_WIDTH-1:0] sext8(input logic [7:0] v);
        return {{(INSTR_WIDTH-8){v[7]}}, v};
    endfunction

    function automatic logic [INSTR_WIDTH-1:0] zext8(input logic [7:0] v);
        return {{(INSTR_WIDTH-8){1'b0}}, v};
    endfunction

    function automatic logic [INSTR_WIDTH-1:0] sext11(input logic [10:0] v);
        return {{(INSTR_WIDTH-11){v[10]}}, v};
    endfunction

    assign opcode_s    = in_instr[15:11];
    // A flush while halted must not kill the draining HALT bundle.
    assign flush_run_s = flush & (state_r == ST_RUN);
    assign in_ready    = (state_r == ST_RUN) & (~out_valid | out_ready) & ~flush;
    assign accept_s    = in_valid & in_ready;
    assign halted      = (state_r == ST_HALTED);

    // Field extraction for the incoming instruction.
    always_comb begin
        dec_funct_s   = 2'b00;
        dec_rs_s      = '0;
        dec_rt_s      = '0;
        dec_rd_s      = '0;
        dec_imm_s     = '0;
        dec_b_imm_s   = 1'b0;
        dec_wr_en_s   = 1'b0;
        dec_illegal_s = 1'b0;
        dec_stop_s    = 1'b0;
        casez (opcode_s)
            5'b010??: begin
                dec_rs_s    = in_instr[10:8];
                dec_rd_s    = in_instr[7:5];
                dec_imm_s   = opcode_s[1] ? zext5(in_instr[4:0]) : sext5(in_instr[4:0]);
                dec_b_imm_s = 1'b1;
                dec_wr_en_s = 1'b1;
            end
            5'b101??: begin
                dec_rs_s    = in_instr[10:8];
                dec_rd_s    = in_instr[7:5];
                dec_imm_s   = zext5(in_instr[4:0]);
                dec_b_imm_s = 1'b1;
                dec_wr_en_s = 1'b1;
            end
            5'b10000, 5'b10001: begin
                dec_rs_s    = in_instr[10:8];
                dec_rd_s    = in_instr[7:5];
                dec_imm_s   = sext5(in_instr[4:0]);
                dec_b_imm_s = 1'b1;
                dec_wr_en_s = opcode_s[0];
            end
            5'b10010: begin
                dec_rs_s    = in_instr[10:8];
                dec_rd_s    = in_instr[10:8];
                dec_imm_s   = zext8(in_instr[7:0]);
                dec_b_imm_s = 1'b1;
                dec_wr_en_s = 1'b1;
            end
            5'b10011: begin
                dec_rs_s    = in_instr[10:8];
                dec_rd_s    = in_instr[10:8];
                dec_imm_s   = sext5(in_instr[4:0]);
                dec_b_imm_s = 1'b1;
                dec_wr_en_s = 1'b1;
            end
            5'b11010, 5'b11011, 5'b111??: begin
                dec_rs_s    = in_instr[10:8];
                dec_rt_s    = in_instr[7:5];
                dec_rd_s    = in_instr[4:2];
                dec_funct_s = opcode_s[2] ? 2'b00 : in_instr[1:0];
                dec_wr_en_s = 1'b1;
            end
            5'b011??: begin
                dec_rs_s  = in_instr[10:8];
                dec_imm_s = sext8(in_instr[7:0]);
            end
            5'b11000: begin
                dec_rd_s    = in_instr[10:8];
                dec_imm_s   = sext8(in_instr[7:0]);
                dec_wr_en_s = 1'b1;
            end
            5'b00100, 5'b00110: begin
                dec_imm_s   = sext11(in_instr[10:0]);
                dec_rd_s    = opcode_s[1] ? LINK_IDX : '0;
                dec_wr_en_s = opcode_s[1];
            end
            5'b00101, 5'b00111: begin
                dec_rs_s    = in_instr[10:8];
                dec_imm_s   = sext8(in_instr[7:0]);
                dec_rd_s    = opcode_s[1] ? LINK_IDX : '0;
                dec_wr_en_s = opcode_s[1];
            end
            5'b00000: begin
                dec_stop_s = 1'b1;
            end
            5'b00010, 5'b00011: begin
`ifdef DECODE_ILLEGAL_TRAP_EN
                dec_illegal_s = 1'b1;
                dec_stop_s    = 1'b1;
`else
                dec_illegal_s = 1'b0;
`endif
            end
            default: begin
                dec_stop_s = 1'b0;
            end
        endcase
    end

    // RUN/HALTED next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_RUN: begin
                if (accept_s && dec_stop_s) begin
                    state_nxt_s = ST_HALTED;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_HALTED: state_nxt_s = ST_HALTED;
            default:   state_nxt_s = ST_RUN;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_RUN;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Output bundle register: load on accept, drop valid on transfer or flush.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid     <= 1'b0;
            out_alu_op    <= 5'b00000;
            out_alu_funct <= 2'b00;
            out_rs        <= '0;
            out_rt        <= '0;
            out_rd        <= '0;
            out_imm       <= '0;
            out_b_imm     <= 1'b0;
            out_wr_en     <= 1'b0;
            out_illegal   <= 1'b0;
        end else if (accept_s) begin
            out_valid     <= 1'b1;
            out_alu_op    <= opcode_s;
            out_alu_funct <= dec_funct_s;
            out_rs        <= dec_rs_s;
            out_rt        <= dec_rt_s;
            out_rd        <= dec_rd_s;
            out_imm       <= dec_imm_s;
            out_b_imm     <= dec_b_imm_s;
            out_wr_en     <= dec_wr_en_s;
            out_illegal   <= dec_illegal_s;
        end else if (flush_run_s || out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_instr_decode_issue.sv
// Randomized self-checking bench for instr_decode_issue with a behavioural decode/handshake model.
module tb_instr_decode_issue;

`ifdef DECODE_ILLEGAL_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    typedef struct packed {
        logic [4:0]  op;
        logic [1:0]  funct;
        logic [2:0]  rs;
        logic [2:0]  rt;
        logic [2:0]  rd;
        logic [15:0] imm;
        logic        b_imm;
        logic        wr_en;
        logic        illegal;
    } bundle_t;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [15:0] in_instr;
    logic        in_ready;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  out_alu_op;
    logic [1:0]  out_alu_funct;
    logic [2:0]  out_rs;
    logic [2:0]  out_rt;
    logic [2:0]  out_rd;
    logic [15:0] out_imm;
    logic        out_b_imm;
    logic        out_wr_en;
    logic        out_illegal;
    logic        halted;

    logic        m_valid;
    logic        m_halted;
    bundle_t     m_b;
    logic        exp_ready;
    int          n_checks;
    int          n_errors;

    wire [36:0] obs = {out_valid, out_alu_op, out_alu_funct, out_rs, out_rt, out_rd,
                       out_imm, out_b_imm, out_wr_en, out_illegal, halted};
    wire [36:0] exp_obs = {m_valid, m_b, m_halted};

    instr_decode_issue dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_instr(in_instr),
        .in_ready(in_ready), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .out_alu_op(out_alu_op), .out_alu_funct(out_alu_funct), .out_rs(out_rs),
        .out_rt(out_rt), .out_rd(out_rd), .out_imm(out_imm), .out_b_imm(out_b_imm),
        .out_wr_en(out_wr_en), .out_illegal(out_illegal), .halted(halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int sx(input int v, input int bits);
        return (v >= (1 << (bits - 1))) ? v - (1 << bits) : v;
    endfunction

    function automatic bundle_t model_decode(input logic [15:0] ins);
        bundle_t b;
        int op, a, m, lo, i5, i8, i11;
        op = int'(ins[15:11]); a = int'(ins[10:8]); m = int'(ins[7:5]); lo = int'(ins[4:2]);
        i5 = int'(ins[4:0]); i8 = int'(ins[7:0]); i11 = int'(ins[10:0]);
        b = '0;
        b.op = ins[15:11];
        if (op >= 8 && op <= 11) begin
            b.rs = 3'(a); b.rd = 3'(m); b.b_imm = 1'b1; b.wr_en = 1'b1;
            b.imm = (op < 10) ? 16'(sx(i5, 5)) : 16'(i5);
        end else if (op >= 20 && op <= 23) begin
            b.rs = 3'(a); b.rd = 3'(m); b.imm = 16'(i5); b.b_imm = 1'b1; b.wr_en = 1'b1;
        end else if (op >= 16 && op <= 19) begin
            b.rs = 3'(a); b.rd = 3'(m); b.imm = 16'(sx(i5, 5)); b.b_imm = 1'b1;
            b.wr_en = (op != 16);
            if (op == 19) b.rd = 3'(a);
            if (op == 18) begin b.rd = 3'(a); b.imm = 16'(i8); end
        end else if (op == 26 || op == 27 || op >= 28) begin
            b.rs = 3'(a); b.rt = 3'(m); b.rd = 3'(lo); b.wr_en = 1'b1;
            b.funct = (op >= 28) ? 2'b00 : ins[1:0];
        end else if (op >= 12 && op <= 15) begin
            b.rs = 3'(a); b.imm = 16'(sx(i8, 8));
        end else if (op == 24) begin
            b.rd = 3'(a); b.imm = 16'(sx(i8, 8)); b.wr_en = 1'b1;
        end else if (op == 4 || op == 6) begin
            b.imm = 16'(sx(i11, 11));
            if (op == 6) begin b.rd = 3'd7; b.wr_en = 1'b1; end
        end else if (op == 5 || op == 7) begin
            b.rs = 3'(a); b.imm = 16'(sx(i8, 8));
            if (op == 7) begin b.rd = 3'd7; b.wr_en = 1'b1; end
        end else if ((op == 2 || op == 3) && TRAP) begin
            b.illegal = 1'b1;
        end
        return b;
    endfunction

    function automatic bit model_stops(input logic [15:0] ins);
        int op;
        op = int'(ins[15:11]);
        return (op == 0) || (TRAP && (op == 2 || op == 3));
    endfunction

    task automatic set_inputs(input logic r, input logic v, input logic [15:0] ins,
                              input logic ordy, input logic fl);
        rst_n = r; in_valid = v; in_instr = ins; out_ready = ordy; flush = fl;
        exp_ready = !m_halted && (!m_valid || ordy) && !fl;
        #1;
    endtask

    task automatic tick();
        logic acc;
        acc = in_valid && exp_ready;
        if (!rst_n) begin
            m_valid = 1'b0; m_b = '0; m_halted = 1'b0;
        end else if (acc) begin
            m_b = model_decode(in_instr); m_valid = 1'b1;
            if (model_stops(in_instr)) m_halted = 1'b1;
        end else if ((flush && !m_halted) || out_ready) begin
            m_valid = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        set_inputs(1'b0, 1'b1, 16'h4125, 1'b1, 1'b0);
        tick(); tick();
        n_checks++;
        if (obs !== 37'd0) begin n_errors++; $display("FAIL reset_state: got %h expected %h", obs, 37'd0); end
        set_inputs(1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
        n_checks++;
        if (in_ready !== 1'b1) begin n_errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        tick();
    endtask

    task automatic test_addi();
        set_inputs(1'b1, 1'b1, 16'h4125, 1'b1, 1'b0);
        tick();
        n_checks++;
        if ({out_valid, out_alu_op, out_rs, out_rd, out_imm, out_b_imm, out_wr_en} !==
            {1'b1, 5'b01000, 3'd1, 3'd1, 16'h0005, 1'b1, 1'b1}) begin
            n_errors++; $display("FAIL addi_bundle: got %h", obs);
        end
        n_checks++;
        if (obs !== exp_obs) begin n_errors++; $display("FAIL addi_model: got %h expected %h", obs, exp_obs); end
    endtask

    task automatic test_back_to_back();
        set_inputs(1'b1, 1'b1, 16'h4A3F, 1'b1, 1'b0);
        tick();
        n_checks++;
        if ({out_valid, out_rs, out_rd, out_imm} !== {1'b1, 3'd2, 3'd1, 16'hFFFF}) begin
            n_errors++; $display("FAIL b2b_subi: got %h", obs);
        end
        set_inputs(1'b1, 1'b1, 16'hD9AD, 1'b1, 1'b0);
        n_checks++;
        if (in_ready !== 1'b1) begin n_errors++; $display("FAIL b2b_ready: got %b expected 1", in_ready); end
        tick();
        n_checks++;
        if ({out_valid, out_rs, out_rt, out_rd, out_alu_funct, out_b_imm, out_wr_en} !==
            {1'b1, 3'd1, 3'd5, 3'd3, 2'b01, 1'b0, 1'b1}) begin
            n_errors++; $display("FAIL b2b_rtype: got %h", obs);
        end
        set_inputs(1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
        tick();
        n_checks++;
        if (out_valid !== 1'b0) begin n_errors++; $display("FAIL b2b_drop: got %b expected 0", out_valid); end
    endtask

    task automatic test_stall();
        logic [36:0] held;
        set_inputs(1'b1, 1'b1, 16'h4125, 1'b1, 1'b0);
        tick();
        held = obs;
        for (int i = 0; i < 3; i++) begin
            set_inputs(1'b1, 1'b1, 16'h4A3F, 1'b0, 1'b0);
            n_checks++;
            if (in_ready !== 1'b0) begin n_errors++; $display("FAIL stall_ready: got %b expected 0", in_ready); end
            tick();
            n_checks++;
            if (obs !== held) begin n_errors++; $display("FAIL stall_hold: got %h expected %h", obs, held); end
        end
        set_inputs(1'b1, 1'b1, 16'h4A3F, 1'b1, 1'b0);
        n_checks++;
        if (in_ready !== 1'b1) begin n_errors++; $display("FAIL stall_release: got %b expected 1", in_ready); end
        tick();
        n_checks++;
        if ({out_valid, out_imm} !== {1'b1, 16'hFFFF}) begin n_errors++; $display("FAIL stall_next: got %h", obs); end
        set_inputs(1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
        tick();
    endtask

    task automatic test_flush();
        set_inputs(1'b1, 1'b1, 16'h4125, 1'b0, 1'b0);
        tick();
        set_inputs(1'b1, 1'b1, 16'hD9AD, 1'b0, 1'b1);
        n_checks++;
        if (in_ready !== 1'b0) begin n_errors++; $display("FAIL flush_ready: got %b expected 0", in_ready); end
        tick();
        n_checks++;
        if (out_valid !== 1'b0) begin n_errors++; $display("FAIL flush_kill: got %b expected 0", out_valid); end
        set_inputs(1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
        tick();
        n_checks++;
        if (obs !== exp_obs || out_valid !== 1'b0) begin
            n_errors++; $display("FAIL flush_noaccept: got %h expected %h", obs, exp_obs);
        end
    endtask

    task automatic test_jal_halt();
        set_inputs(1'b1, 1'b1, 16'h37FF, 1'b1, 1'b0);
        tick();
        n_checks++;
        if ({out_valid, out_rd, out_imm, out_wr_en} !== {1'b1, 3'd7, 16'hFFFF, 1'b1}) begin
            n_errors++; $display("FAIL jal_bundle: got %h", obs);
        end
        set_inputs(1'b1, 1'b1, 16'h0000, 1'b1, 1'b0);
        tick();
        n_checks++;
        if (obs !== {1'b1, 35'd0, 1'b1}) begin n_errors++; $display("FAIL halt_bundle: got %h", obs); end
        set_inputs(1'b1, 1'b1, 16'h4125, 1'b0, 1'b1);
        tick();
        n_checks++;
        if ({out_valid, halted} !== 2'b11) begin n_errors++; $display("FAIL halt_flush: got %b%b expected 11", out_valid, halted); end
        for (int i = 0; i < 3; i++) begin
            set_inputs(1'b1, 1'b1, 16'h4125, 1'b1, 1'b0);
            n_checks++;
            if (in_ready !== 1'b0) begin n_errors++; $display("FAIL halted_ready: got %b expected 0", in_ready); end
            tick();
            n_checks++;
            if (obs !== exp_obs) begin n_errors++; $display("FAIL halted_state: got %h expected %h", obs, exp_obs); end
        end
        set_inputs(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        tick();
        set_inputs(1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
        n_checks++;
        if ({halted, in_ready} !== 2'b01) begin n_errors++; $display("FAIL halt_reset: got %b%b expected 01", halted, in_ready); end
        tick();
    endtask

    task automatic test_illegal();
        set_inputs(1'b1, 1'b1, 16'h1000, 1'b1, 1'b0);
        tick();
        n_checks++;
`ifdef DECODE_ILLEGAL_TRAP_EN
        if ({out_valid, out_illegal, out_wr_en, halted} !== 4'b1101) begin
            n_errors++; $display("FAIL illegal_trap: got %h", obs);
        end
`else
        if ({out_valid, out_illegal, out_wr_en, halted} !== 4'b1000) begin
            n_errors++; $display("FAIL illegal_nop: got %h", obs);
        end
`endif
        set_inputs(1'b1, 1'b1, 16'h4125, 1'b1, 1'b0);
        n_checks++;
        if (in_ready !== !TRAP) begin n_errors++; $display("FAIL illegal_ready: got %b expected %b", in_ready, !TRAP); end
        tick();
        n_checks++;
        if (obs !== exp_obs) begin n_errors++; $display("FAIL illegal_model: got %h expected %h", obs, exp_obs); end
        set_inputs(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        tick();
    endtask

    task automatic test_random();
        logic [15:0] ins;
        logic        r;
        int          op;
        for (int i = 0; i < 400; i++) begin
            op = int'($urandom_range(1, 31));
            if (op == 25 || (TRAP && (op == 2 || op == 3))) op = 8;
            ins = {5'(op), 11'($urandom)};
            r = ($urandom_range(0, 63) != 0);
            set_inputs(r, ($urandom_range(0, 3) != 0), ins, ($urandom_range(0, 3) != 0),
                       ($urandom_range(0, 15) == 0));
            if (r) begin
                n_checks++;
                if (in_ready !== exp_ready) begin
                    n_errors++; $display("FAIL rand_ready: cycle %0d got %b expected %b", i, in_ready, exp_ready);
                end
            end
            tick();
            n_checks++;
            if (obs !== exp_obs) begin
                n_errors++; $display("FAIL rand_bundle: cycle %0d got %h expected %h", i, obs, exp_obs);
            end
        end
    endtask

    initial begin
        n_checks = 0; n_errors = 0;
        m_valid = 1'b0; m_halted = 1'b0; m_b = '0; exp_ready = 1'b0;
        rst_n = 1'b0; in_valid = 1'b0; in_instr = 16'h0000; out_ready = 1'b0; flush = 1'b0;
        test_reset();
        test_addi();
        test_back_to_back();
        test_stall();
        test_flush();
        test_jal_halt();
        test_illegal();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
